regfile_2r1w: RTL and testbench
===============================

// Module: regfile_2r1w
// PURPOSE
//   Parametrised register file: one write port, two registered read ports, write-first forwarding.
//   Adds a sequenced bulk-clear engine so software or control can zero the file without a reset.
//   Sits between the ALU result bus (write side) and the operand muxes (read A/B) in the datapath.
// PARAMETERS
//   DATA_W  16  width of each register entry in bits
//   DEPTH   16  number of entries; need not be a power of two
//   ADDR_W  4   address width; must satisfy 2**ADDR_W >= DEPTH
// PORTS
//   clk        in   1       single clock; all state changes on the rising edge
//   reset      in   1       asynchronous, active-high reset
//   wr_en      in   1       write strobe
//   wr_addr    in   ADDR_W  write index
//   wr_data    in   DATA_W  write data (ALU bus)
//   rd_addr_a  in   ADDR_W  read port A index
//   rd_addr_b  in   ADDR_W  read port B index
//   rd_data_a  out  DATA_W  port A data, registered
//   rd_data_b  out  DATA_W  port B data, registered
//   clear_req  in   1       start bulk clear; sampled only in IDLE
//   clear_busy out  1       high while the clear walk is in progress
//   clear_done out  1       one-cycle pulse when the clear completes
// BEHAVIOUR
//   Reset (async assert, released at the next clk edge):
//   - all entries 0; rd_data_a/b 0; FSM IDLE; clear_busy 0; clear_done 0; clear index 0.
//   Write:
//   - wr_en=1 and wr_addr<DEPTH: entry updates at the clk edge.
//   - wr_addr>=DEPTH: write silently dropped.
//   Read:
//   - 1-cycle latency: rd_data_x at edge N+1 reflects rd_addr_x at edge N.
//   - rd_addr_x>=DEPTH returns 0.
//   Forwarding (write-first):
//   - In IDLE, if wr_en=1 and wr_addr==rd_addr_x (in range), rd_data_x gets wr_data, not the stale entry.
//   - Applies independently to A and B; both may forward the same write.
//   Clear FSM: IDLE -> CLEAR -> DONE -> IDLE.
//   - IDLE: clear_req=1 -> CLEAR with idx=0.
//   - CLEAR: each cycle entry[idx]<=0, idx++; clear_busy=1.
//     After writing idx=DEPTH-1 -> DONE (exactly DEPTH cycles in CLEAR).
//   - DONE: clear_done=1 for one cycle, clear_busy=0 -> IDLE.
//   - Start latency: clear_busy rises the cycle after clear_req is sampled;
//     clear_done occurs DEPTH+1 cycles after that edge.
//   Simultaneous events:
//   - wr_en during CLEAR or DONE: write dropped; no forwarding.
//   - Reads during CLEAR return current array contents (a partially cleared mix is legal).
//   - clear_req during CLEAR or DONE: ignored (not queued).
//   - clear_req and wr_en together in IDLE: the write completes, then the clear erases it.
//   - reset mid-clear: immediate abort to IDLE, all entries 0, no clear_done pulse.
// CONFIGURATION
//   ZERO_REG_EN defined:
//   - entry 0 is hardwired to 0; writes to address 0 dropped; reads of address 0 return 0.
//   - no forwarding for address 0; the clear walk still takes DEPTH cycles.
//   ZERO_REG_EN undefined: entry 0 is an ordinary read/write register.
// TESTING
//   1 Reset, then read A=3, B=15 -> both 0x0000 one cycle later; clear_busy=0.
//   2 Write 0x1234 to r5, next cycle read A=5 -> 0x1234 after 1 cycle; read B=6 -> 0x0000.
//   3 Same cycle wr r7=0xBEEF and rd A=7, B=7 -> both 0xBEEF on the next edge (forwarding).
//   4 Fill r0..r15 with 0xA5A5, pulse clear_req, wr r2=0xFFFF mid-clear
//     -> busy 16 cycles, single done pulse, all entries 0, r2 write dropped.
//   5 Assert reset at clear idx=8 -> busy falls at once, no done pulse, all reads 0;
//     a new clear_req restarts from idx 0.
//   6 ZERO_REG_EN: wr r0=0xFFFF, read A=0 -> 0x0000; undefined: same stimulus -> 0xFFFF.

Source files
------------

// File: rtl/regfile_2r1w_if.sv
// ---------------------------------------------------------------------------
// regfile_2r1w_if
// Bundles the datapath-facing signals of the 2-read / 1-write register file.
//   master : drives write port, both read addresses and clear_req;
//            receives rd_data_a/b, clear_busy, clear_done
//   slave  : the register file side of the same bundle
// Parameters:
//   DATA_W  width of each register entry
//   ADDR_W  width of the write/read indices
// ---------------------------------------------------------------------------
interface regfile_2r1w_if #(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 4
);
    logic              wr_en;
    logic [ADDR_W-1:0] wr_addr;
    logic [DATA_W-1:0] wr_data;
    logic [ADDR_W-1:0] rd_addr_a;
    logic [ADDR_W-1:0] rd_addr_b;
    logic [DATA_W-1:0] rd_data_a;
    logic [DATA_W-1:0] rd_data_b;
    logic              clear_req;
    logic              clear_busy;
    logic              clear_done;

    modport master (
        output wr_en, wr_addr, wr_data, rd_addr_a, rd_addr_b, clear_req,
        input  rd_data_a, rd_data_b, clear_busy, clear_done
    );

    modport slave (
        input  wr_en, wr_addr, wr_data, rd_addr_a, rd_addr_b, clear_req,
        output rd_data_a, rd_data_b, clear_busy, clear_done
    );
endinterface

// File: rtl/regfile_2r1w.sv
// ---------------------------------------------------------------------------
// regfile_2r1w
// Register file with one write port and two registered read ports.
// Reads see a same-cycle write (write-first forwarding). A small FSM walks
// the array and zeroes one entry per cycle so the file can be cleared
// without a reset.
// Ports:
//   clk    rising-edge clock
//   reset  asynchronous, active-high reset
//   bus    regfile_2r1w_if.slave: write port, read ports A/B, clear
//          request plus clear_busy / clear_done status
// Optional feature macro: ZERO_REG_EN
//   defined   -> entry 0 is hardwired to zero (writes dropped, reads 0,
//                never forwarded); the clear walk still covers DEPTH entries
//   undefined -> entry 0 is an ordinary register
// ---------------------------------------------------------------------------
module regfile_2r1w #(
    parameter int DATA_W = 16,
    parameter int DEPTH  = 16,
    parameter int ADDR_W = 4
) (
    input  logic           clk,
    input  logic           reset,
    regfile_2r1w_if.slave  bus
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_CLEAR = 2'd1,
        ST_DONE  = 2'd2
    } state_e;

`ifdef ZERO_REG_EN
    localparam int FIRST_ENTRY = 1;
`else
    localparam int FIRST_ENTRY = 0;
`endif

    // One extra bit so the range check works when DEPTH == 2**ADDR_W.
    localparam logic [ADDR_W:0]   DEPTH_EXT = (ADDR_W+1)'(DEPTH);
    localparam logic [ADDR_W-1:0] LAST_IDX  = ADDR_W'(DEPTH-1);

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] idx_q, idx_d;
    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [DATA_W-1:0] mem_d [DEPTH];
    logic [DATA_W-1:0] rd_data_a_q, rd_data_a_d;
    logic [DATA_W-1:0] rd_data_b_q, rd_data_b_d;
    logic              wr_hit;

    // A write only lands while idle, in range, and not to a hardwired entry.
    always_comb begin
        wr_hit = (state_q == ST_IDLE) && bus.wr_en &&
                 ({1'b0, bus.wr_addr} < DEPTH_EXT) &&
                 (int'(bus.wr_addr) >= FIRST_ENTRY);
    end

    // Clear sequencer: IDLE -> CLEAR (DEPTH cycles) -> DONE -> IDLE.
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        case (state_q)
            ST_IDLE: begin
                if (bus.clear_req) begin
                    state_d = ST_CLEAR;
                    idx_d   = '0;
                end
            end
            ST_CLEAR: begin
                if (idx_q == LAST_IDX) begin
                    state_d = ST_DONE;
                    idx_d   = '0;
                end else begin
                    idx_d = idx_q + 1'b1;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
                idx_d   = '0;
            end
        endcase
    end

    // Next array contents: the write port and the clear walk never overlap,
    // because writes are only accepted in IDLE.
    always_comb begin
        for (int i = 0; i < DEPTH; i++) begin
            mem_d[i] = mem_q[i];
            if (wr_hit && (bus.wr_addr == ADDR_W'(i))) begin
                mem_d[i] = bus.wr_data;
            end
            if ((state_q == ST_CLEAR) && (idx_q == ADDR_W'(i))) begin
                mem_d[i] = '0;
            end
        end
`ifdef ZERO_REG_EN
        mem_d[0] = '0;
`endif
    end

    // Read mux with write-first forwarding; out-of-range and hardwired
    // addresses fall through to the zero default.
    always_comb begin
        rd_data_a_d = '0;
        rd_data_b_d = '0;
        for (int i = FIRST_ENTRY; i < DEPTH; i++) begin
            if (bus.rd_addr_a == ADDR_W'(i)) rd_data_a_d = mem_q[i];
            if (bus.rd_addr_b == ADDR_W'(i)) rd_data_b_d = mem_q[i];
        end
        if (wr_hit && (bus.wr_addr == bus.rd_addr_a)) rd_data_a_d = bus.wr_data;
        if (wr_hit && (bus.wr_addr == bus.rd_addr_b)) rd_data_b_d = bus.wr_data;
    end

    // State, array and read registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            idx_q       <= '0;
            rd_data_a_q <= '0;
            rd_data_b_q <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            state_q     <= state_d;
            idx_q       <= idx_d;
            rd_data_a_q <= rd_data_a_d;
            rd_data_b_q <= rd_data_b_d;
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= mem_d[i];
            end
        end
    end

    assign bus.rd_data_a  = rd_data_a_q;
    assign bus.rd_data_b  = rd_data_b_q;
    assign bus.clear_busy = (state_q == ST_CLEAR);
    assign bus.clear_done = (state_q == ST_DONE);

endmodule

// File: tb/tb_regfile_2r1w.sv
// ---------------------------------------------------------------------------
// tb_regfile_2r1w
// Scoreboard bench for regfile_2r1w. Each stimulus cycle computes the
// expected read data and clear status from a plain array model, pushes it
// into a queue, and a monitor pops and compares once the DUT has clocked.
// ---------------------------------------------------------------------------
module tb_regfile_2r1w;

    localparam int DATA_W = 16;
    localparam int DEPTH  = 16;
    localparam int ADDR_W = 4;

`ifdef ZERO_REG_EN
    localparam bit ZERO_REG = 1'b1;
`else
    localparam bit ZERO_REG = 1'b0;
`endif

    typedef struct {
        int                cyc;
        logic [DATA_W-1:0] a;
        logic [DATA_W-1:0] b;
        logic              busy;
        logic              done;
    } exp_t;

    logic clk   = 1'b0;
    logic reset = 1'b0;
    int   cyc   = 0;
    int   tests_run    = 0;
    int   tests_failed = 0;

    exp_t              sb_q[$];
    logic [DATA_W-1:0] model_mem [DEPTH];
    int                model_phase;
    int                model_k;

    regfile_2r1w_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) bus ();

    regfile_2r1w #(.DATA_W(DATA_W), .DEPTH(DEPTH), .ADDR_W(ADDR_W)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc = cyc + 1;

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        tests_run++;
        if (actual !== expected) begin
            tests_failed++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)",
                     name, actual, expected, cyc);
        end
    endtask

    function automatic bit writable(input logic [ADDR_W-1:0] addr);
        return (int'(addr) < DEPTH) && !(ZERO_REG && (addr == '0));
    endfunction

    function automatic logic [DATA_W-1:0] model_read(
        input logic [ADDR_W-1:0] addr, input logic we,
        input logic [ADDR_W-1:0] wa, input logic [DATA_W-1:0] wd);
        if (int'(addr) >= DEPTH) return '0;
        if (ZERO_REG && (addr == '0)) return '0;
        if ((model_phase == 0) && we && writable(wa) && (wa == addr)) return wd;
        return model_mem[addr];
    endfunction

    task automatic model_reset();
        for (int i = 0; i < DEPTH; i++) model_mem[i] = '0;
        model_phase = 0;
        model_k     = 0;
    endtask

    // One clock of stimulus: drive, predict, push, advance the model.
    task automatic applyStimulus(input logic we, input logic [ADDR_W-1:0] wa,
                                 input logic [DATA_W-1:0] wd,
                                 input logic [ADDR_W-1:0] ra,
                                 input logic [ADDR_W-1:0] rb,
                                 input logic cr);
        exp_t e;
        bus.wr_en     = we;
        bus.wr_addr   = wa;
        bus.wr_data   = wd;
        bus.rd_addr_a = ra;
        bus.rd_addr_b = rb;
        bus.clear_req = cr;
        e.cyc = cyc;
        e.a   = model_read(ra, we, wa, wd);
        e.b   = model_read(rb, we, wa, wd);
        case (model_phase)
            0: begin
                if (we && writable(wa)) model_mem[wa] = wd;
                if (cr) begin
                    model_phase = 1;
                    model_k     = 0;
                end
            end
            1: begin
                model_mem[model_k] = '0;
                model_k++;
                if (model_k == DEPTH) model_phase = 2;
            end
            default: model_phase = 0;
        endcase
        e.busy = (model_phase == 1);
        e.done = (model_phase == 2);
        sb_q.push_back(e);
        @(posedge clk);
        #1;
    endtask

    task automatic idleCycle(input logic [ADDR_W-1:0] ra, input logic [ADDR_W-1:0] rb);
        applyStimulus(1'b0, '0, '0, ra, rb, 1'b0);
    endtask

    // Asynchronous reset asserted between edges; outputs must clear at once.
    task automatic doReset();
        bus.wr_en     = 1'b0;
        bus.clear_req = 1'b0;
        reset = 1'b1;
        #1;
        checkOutput("reset_rd_data_a", 32'(bus.rd_data_a), 32'h0);
        checkOutput("reset_rd_data_b", 32'(bus.rd_data_b), 32'h0);
        checkOutput("reset_clear_busy", 32'(bus.clear_busy), 32'h0);
        checkOutput("reset_clear_done", 32'(bus.clear_done), 32'h0);
        model_reset();
        sb_q.delete();
        @(posedge clk);
        #1;
        reset = 1'b0;
    endtask

    // Monitor: compare every expectation whose response edge has passed.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            while ((sb_q.size() > 0) && (sb_q[0].cyc < cyc)) begin
                e = sb_q.pop_front();
                checkOutput("rd_data_a", 32'(bus.rd_data_a), 32'(e.a));
                checkOutput("rd_data_b", 32'(bus.rd_data_b), 32'(e.b));
                checkOutput("clear_busy", 32'(bus.clear_busy), 32'(e.busy));
                checkOutput("clear_done", 32'(bus.clear_done), 32'(e.done));
            end
        end
    end

    initial begin
        logic              we;
        logic              cr;
        logic [ADDR_W-1:0] wa;
        logic [ADDR_W-1:0] ra;
        logic [ADDR_W-1:0] rb;
        logic [DATA_W-1:0] wd;

        bus.wr_en     = 1'b0;
        bus.wr_addr   = '0;
        bus.wr_data   = '0;
        bus.rd_addr_a = '0;
        bus.rd_addr_b = '0;
        bus.clear_req = 1'b0;
        model_reset();
        #2;
        doReset();

        // Reset contents read back as zero.
        idleCycle(ADDR_W'(3), ADDR_W'(15));

        // Plain write then read; neighbouring entry untouched.
        applyStimulus(1'b1, ADDR_W'(5), 16'h1234, '0, '0, 1'b0);
        idleCycle(ADDR_W'(5), ADDR_W'(6));

        // Same-cycle write and read on both ports: forwarding.
        applyStimulus(1'b1, ADDR_W'(7), 16'hBEEF, ADDR_W'(7), ADDR_W'(7), 1'b0);
        idleCycle(ADDR_W'(7), ADDR_W'(5));

        // Entry 0: ordinary register unless hardwired.
        applyStimulus(1'b1, '0, 16'hFFFF, '0, '0, 1'b0);
        idleCycle('0, ADDR_W'(7));

        // Fill, clear, and try a write and a second request mid-clear.
        for (int i = 0; i < DEPTH; i++)
            applyStimulus(1'b1, ADDR_W'(i), 16'hA5A5, ADDR_W'(i), ADDR_W'((i + 1) % DEPTH), 1'b0);
        applyStimulus(1'b0, '0, '0, ADDR_W'(2), ADDR_W'(9), 1'b1);
        for (int k = 0; k < DEPTH + 2; k++)
            applyStimulus(k == 5, ADDR_W'(2), 16'hFFFF, ADDR_W'(2), ADDR_W'(k % DEPTH), k == 3);
        for (int i = 0; i < DEPTH; i++)
            idleCycle(ADDR_W'(i), ADDR_W'(DEPTH - 1 - i));

        // Reset in the middle of a clear walk, then a fresh clear.
        for (int i = 0; i < DEPTH; i++)
            applyStimulus(1'b1, ADDR_W'(i), DATA_W'(16'h1000 + i), '0, '0, 1'b0);
        applyStimulus(1'b0, '0, '0, '0, '0, 1'b1);
        for (int k = 0; k < 8; k++) idleCycle(ADDR_W'(k), ADDR_W'(k + 8));
        @(negedge clk);
        #1;
        doReset();
        idleCycle(ADDR_W'(12), ADDR_W'(3));
        for (int i = 0; i < 4; i++)
            applyStimulus(1'b1, ADDR_W'(i + 8), DATA_W'(16'h7700 + i), ADDR_W'(i), '0, 1'b0);
        // Write and clear request together: write lands, then is erased.
        applyStimulus(1'b1, ADDR_W'(9), 16'h5555, ADDR_W'(9), ADDR_W'(9), 1'b1);
        for (int k = 0; k < DEPTH + 2; k++)
            idleCycle(ADDR_W'(k % DEPTH), ADDR_W'(9));
        for (int i = 0; i < DEPTH; i++)
            idleCycle(ADDR_W'(i), ADDR_W'(i));

        // Randomised traffic with occasional clears.
        for (int n = 0; n < 400; n++) begin
            we = 1'($urandom_range(0, 1));
            wa = ADDR_W'($urandom_range(0, DEPTH - 1));
            wd = DATA_W'($urandom);
            ra = ($urandom_range(0, 3) == 0) ? wa : ADDR_W'($urandom_range(0, DEPTH - 1));
            rb = ($urandom_range(0, 3) == 0) ? wa : ADDR_W'($urandom_range(0, DEPTH - 1));
            cr = ($urandom_range(0, 39) == 0);
            applyStimulus(we, wa, wd, ra, rb, cr);
        end

        idleCycle('0, '0);
        @(negedge clk);
        #1;
        checkOutput("scoreboard_drained", 32'(sb_q.size()), 32'h0);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
